// File: rtl/accel_bus_router.sv
// Single-outstanding router: round-robin masters onto a parameter-mapped slave set, with timeout and hung-slave isolation.
// Latency 3 cycles to a zero-wait slave, 1 on decode/hung error; masters stall on o_req_ready, responses hold until i_resp_ready.
module accel_bus_router #(
  parameter int NMST = 2,
  parameter int NSLV = 6,
  parameter int AW = 64,
  parameter int DW = 64,
  parameter logic [NSLV*AW-1:0] MAP_START = {
    64'h0000_0000_8000_0000,  // ddr
    64'h0000_0000_1000_0000,  // apb bridge
    64'h0000_0000_0c00_0000,  // plic
    64'h0000_0000_0800_0000,  // sram
    64'h0000_0000_0200_0000,  // clint
    64'h0000_0000_0001_0000   // bootrom
  },
  parameter logic [NSLV*AW-1:0] MAP_END = {
    64'h0000_0001_0000_0000,
    64'h0000_0000_2000_0000,
    64'h0000_0000_1000_0000,
    64'h0000_0000_0810_0000,
    64'h0000_0000_0201_0000,
    64'h0000_0000_0002_0000
  },
  parameter int TIMEOUT = 1024
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NMST-1:0]    i_req_valid,
  input  logic [NMST*AW-1:0] i_req_addr,
  input  logic [NMST-1:0]    i_req_write,
  input  logic [NMST*DW-1:0] i_req_wdata,
  output logic [NMST-1:0]    o_req_ready,
  output logic [NMST-1:0]    o_resp_valid,
  output logic [DW-1:0]      o_resp_rdata,
  output logic [1:0]         o_resp_err,
  input  logic [NMST-1:0]    i_resp_ready,
  output logic [NSLV-1:0]    o_slv_req_valid,
  output logic [AW-1:0]      o_slv_req_addr,
  output logic               o_slv_req_write,
  output logic [DW-1:0]      o_slv_req_wdata,
  input  logic [NSLV-1:0]    i_slv_req_ready,
  input  logic [NSLV-1:0]    i_slv_resp_valid,
  input  logic [NSLV*DW-1:0] i_slv_resp_rdata,
  input  logic [NSLV-1:0]    i_slv_resp_err,
  output logic [NSLV-1:0]    o_slv_resp_ready
);

  localparam int MW = (NMST > 1) ? $clog2(NMST) : 1;
  localparam int SW = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, SREQ, SWAIT, RESP} state_t;

  state_t          state;
  logic [MW-1:0]   rr;
  logic [MW-1:0]   gnt_q;
  logic [SW-1:0]   sel_q;
  logic [AW-1:0]   addr_q;
  logic            write_q;
  logic [DW-1:0]   wdata_q;
  logic [DW-1:0]   rdata_q;
  logic [1:0]      err_q;
  logic [NSLV-1:0] hung;
  logic [CW-1:0]   cnt;

  logic            any_req;
  logic [MW-1:0]   gnt;
  int              idx;

  always_comb begin
    any_req = 1'b0;
    gnt = '0;
    idx = 0;
    for (int k = 0; k < NMST; k++) begin
      idx = int'(rr) + k;
      if (idx >= NMST) idx = idx - NMST;
      if (!any_req && i_req_valid[idx]) begin
        any_req = 1'b1;
        gnt = MW'(idx);
      end
    end
  end

  logic [AW-1:0] req_addr;
  logic          req_write;
  logic [DW-1:0] req_wdata;

  assign req_addr  = i_req_addr[gnt*AW +: AW];
  assign req_write = i_req_write[gnt];
  assign req_wdata = i_req_wdata[gnt*DW +: DW];

  // Decode runs on the granted master's address so the latched copy and the decision agree.
  logic          hit;
  logic [SW-1:0] hit_s;
  logic [AW-1:0] rel_addr;

  always_comb begin
    hit = 1'b0;
    hit_s = '0;
    for (int s = 0; s < NSLV; s++) begin
      if (!hit && req_addr >= MAP_START[s*AW +: AW] && req_addr < MAP_END[s*AW +: AW]) begin
        hit = 1'b1;
        hit_s = SW'(s);
      end
    end
  end

  assign rel_addr = req_addr - MAP_START[hit_s*AW +: AW];

  logic          slv_req_rdy;
  logic          slv_rsp_vld;
  logic [DW-1:0] slv_rdata;
  logic          slv_err;
  logic          tmo;

  assign slv_req_rdy = i_slv_req_ready[sel_q];
  assign slv_rsp_vld = i_slv_resp_valid[sel_q];
  assign slv_rdata   = i_slv_resp_rdata[sel_q*DW +: DW];
  assign slv_err     = i_slv_resp_err[sel_q];
  assign tmo         = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= IDLE;
      rr      <= '0;
      gnt_q   <= '0;
      sel_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 2'b00;
      hung    <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt_q   <= gnt;
            sel_q   <= hit_s;
            addr_q  <= rel_addr;
            write_q <= req_write;
            wdata_q <= req_wdata;
            cnt     <= '0;
            if (!hit) begin
              rdata_q <= '0;
              err_q   <= 2'b11;
              state   <= RESP;
            end else if (hung[hit_s]) begin
              rdata_q <= '0;
              err_q   <= 2'b10;
              state   <= RESP;
            end else begin
              state <= SREQ;
            end
          end
        end
        SREQ: begin
          cnt <= cnt + 1'b1;
          if (tmo) begin
            hung[sel_q] <= 1'b1;
            rdata_q     <= '0;
            err_q       <= 2'b10;
            state       <= RESP;
          end else if (slv_req_rdy) begin
            state <= SWAIT;
          end
        end
        SWAIT: begin
          cnt <= cnt + 1'b1;
          // A response landing on the timeout cycle is still taken as a normal completion.
          if (slv_rsp_vld) begin
            rdata_q <= slv_rdata;
            err_q   <= slv_err ? 2'b10 : 2'b00;
            state   <= RESP;
          end else if (tmo) begin
            hung[sel_q] <= 1'b1;
            rdata_q     <= '0;
            err_q       <= 2'b10;
            state       <= RESP;
          end
        end
        RESP: begin
          if (i_resp_ready[gnt_q]) begin
            rr    <= (gnt_q == MW'(NMST - 1)) ? '0 : gnt_q + 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    o_req_ready = '0;
    o_resp_valid = '0;
    o_slv_req_valid = '0;
    o_slv_resp_ready = '0;
    // Reset gates the only combinational output so every output reads 0 while i_rst is high.
    if (state == IDLE && any_req && !i_rst) o_req_ready[gnt] = 1'b1;
    if (state == SREQ) o_slv_req_valid[sel_q] = 1'b1;
    if (state == SWAIT) o_slv_resp_ready[sel_q] = 1'b1;
    if (state == RESP) o_resp_valid[gnt_q] = 1'b1;
  end

  assign o_slv_req_addr  = (state == SREQ) ? addr_q : '0;
  assign o_slv_req_write = (state == SREQ) ? write_q : 1'b0;
  assign o_slv_req_wdata = (state == SREQ) ? wdata_q : '0;
  assign o_resp_rdata    = (state == RESP) ? rdata_q : '0;
  assign o_resp_err      = (state == RESP) ? err_q : 2'b00;

endmodule

// File: tb/tb_accel_bus_router.sv
// Directed bench for accel_bus_router: queued master stimulus, slave models with programmable delay, scoreboard monitor.
// Expected slave requests and master responses are pushed at issue time and popped by the monitor.
module tb_accel_bus_router;
  localparam int NMST = 2;
  localparam int NSLV = 6;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int TMO = 8;
  localparam int OW = 2*NMST + DW + 2 + 2*NSLV + AW + 1 + DW;

  // Same as the bus-0 map, except the APB window starts inside the PLIC window to create an overlap.
  localparam logic [NSLV*AW-1:0] MS = {
    64'h0000_0000_8000_0000, 64'h0000_0000_0f00_0000, 64'h0000_0000_0c00_0000,
    64'h0000_0000_0800_0000, 64'h0000_0000_0200_0000, 64'h0000_0000_0001_0000};
  localparam logic [NSLV*AW-1:0] ME = {
    64'h0000_0001_0000_0000, 64'h0000_0000_2000_0000, 64'h0000_0000_1000_0000,
    64'h0000_0000_0810_0000, 64'h0000_0000_0201_0000, 64'h0000_0000_0002_0000};

  logic              clk;
  logic              rst;
  logic [NMST-1:0]    i_req_valid;
  logic [NMST*AW-1:0] i_req_addr;
  logic [NMST-1:0]    i_req_write;
  logic [NMST*DW-1:0] i_req_wdata;
  logic [NMST-1:0]    o_req_ready;
  logic [NMST-1:0]    o_resp_valid;
  logic [DW-1:0]      o_resp_rdata;
  logic [1:0]         o_resp_err;
  logic [NMST-1:0]    i_resp_ready;
  logic [NSLV-1:0]    o_slv_req_valid;
  logic [AW-1:0]      o_slv_req_addr;
  logic               o_slv_req_write;
  logic [DW-1:0]      o_slv_req_wdata;
  logic [NSLV-1:0]    i_slv_req_ready;
  logic [NSLV-1:0]    i_slv_resp_valid;
  logic [NSLV*DW-1:0] i_slv_resp_rdata;
  logic [NSLV-1:0]    i_slv_resp_err;
  logic [NSLV-1:0]    o_slv_resp_ready;
  logic [OW-1:0]      outs;

  assign i_resp_ready = '1;
  assign i_slv_req_ready = '1;
  assign outs = {o_req_ready, o_resp_valid, o_resp_rdata, o_resp_err, o_slv_req_valid,
                 o_slv_resp_ready, o_slv_req_addr, o_slv_req_write, o_slv_req_wdata};

  accel_bus_router #(.NMST(NMST), .NSLV(NSLV), .AW(AW), .DW(DW),
                     .MAP_START(MS), .MAP_END(ME), .TIMEOUT(TMO)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_write(i_req_write),
    .i_req_wdata(i_req_wdata), .o_req_ready(o_req_ready),
    .o_resp_valid(o_resp_valid), .o_resp_rdata(o_resp_rdata), .o_resp_err(o_resp_err),
    .i_resp_ready(i_resp_ready),
    .o_slv_req_valid(o_slv_req_valid), .o_slv_req_addr(o_slv_req_addr),
    .o_slv_req_write(o_slv_req_write), .o_slv_req_wdata(o_slv_req_wdata),
    .i_slv_req_ready(i_slv_req_ready), .i_slv_resp_valid(i_slv_resp_valid),
    .i_slv_resp_rdata(i_slv_resp_rdata), .i_slv_resp_err(i_slv_resp_err),
    .o_slv_resp_ready(o_slv_resp_ready));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct { logic [AW-1:0] addr; logic wr; logic [DW-1:0] wdata; } mreq_t;
  typedef struct { logic [NSLV-1:0] oh; logic [AW-1:0] addr; logic wr; logic [DW-1:0] wdata; } exp_sreq_t;
  typedef struct { int m; logic [DW-1:0] rdata; logic [1:0] err; int lat; int gw; } exp_resp_t;

  mreq_t     mq[NMST][$];
  exp_sreq_t sq[$];
  exp_resp_t rq[$];

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int pres_cyc[NMST];
  int gnt_cyc[NMST];
  int gwait[NMST];
  int dly[NSLV];
  logic [DW-1:0] sdata[NSLV];
  logic [NSLV-1:0] serr;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Master driver: holds each request until o_req_ready, then presents the next one.
  logic [NMST-1:0] acc;
  initial begin
    i_req_valid = '0;
    i_req_addr = '0;
    i_req_write = '0;
    i_req_wdata = '0;
    forever begin
      @(negedge clk);
      acc = o_req_ready & i_req_valid;
      @(posedge clk);
      #1;
      for (int m = 0; m < NMST; m++) begin
        if (acc[m]) mq[m].delete(0);
        if (mq[m].size() > 0) begin
          if (!i_req_valid[m] || acc[m]) pres_cyc[m] = cyc;
          i_req_valid[m] = 1'b1;
          i_req_addr[m*AW +: AW] = mq[m][0].addr;
          i_req_write[m] = mq[m][0].wr;
          i_req_wdata[m*DW +: DW] = mq[m][0].wdata;
        end else begin
          i_req_valid[m] = 1'b0;
        end
      end
    end
  end

  // Slave models: always request-ready; response dly[s] cycles after the zero-wait slot, never if dly < 0.
  logic [NSLV-1:0] rq_hs, rs_hs, pend;
  int wcnt[NSLV];
  initial begin
    i_slv_resp_valid = '0;
    i_slv_resp_rdata = '0;
    i_slv_resp_err = '0;
    pend = '0;
    forever begin
      @(negedge clk);
      rq_hs = o_slv_req_valid & i_slv_req_ready;
      rs_hs = i_slv_resp_valid & o_slv_resp_ready;
      @(posedge clk);
      #1;
      for (int s = 0; s < NSLV; s++) begin
        i_slv_resp_rdata[s*DW +: DW] = sdata[s];
        i_slv_resp_err[s] = serr[s];
        if (rst) begin
          i_slv_resp_valid[s] = 1'b0;
          pend[s] = 1'b0;
        end else begin
          if (rs_hs[s]) i_slv_resp_valid[s] = 1'b0;
          if (rq_hs[s] && dly[s] >= 0) begin
            pend[s] = 1'b1;
            wcnt[s] = dly[s];
          end
          if (pend[s]) begin
            if (wcnt[s] == 0) begin
              i_slv_resp_valid[s] = 1'b1;
              pend[s] = 1'b0;
            end else begin
              wcnt[s] = wcnt[s] - 1;
            end
          end
        end
      end
    end
  end

  // Monitor / scoreboard.
  exp_sreq_t es;
  exp_resp_t er;
  logic [NMST-1:0] exp_oh;
  initial begin
    forever begin
      @(negedge clk);
      for (int m = 0; m < NMST; m++) begin
        if (o_req_ready[m]) begin
          gnt_cyc[m] = cyc;
          gwait[m] = cyc - pres_cyc[m];
        end
      end
      if (o_slv_req_valid != '0) begin
        if (sq.size() == 0) begin
          check("unexpected_slv_req", o_slv_req_valid, 0);
        end else begin
          es = sq.pop_front();
          check("slv_req_valid", o_slv_req_valid, es.oh);
          check("slv_req_addr", o_slv_req_addr, es.addr);
          check("slv_req_write", o_slv_req_write, es.wr);
          check("slv_req_wdata", o_slv_req_wdata, es.wdata);
        end
      end
      if (o_resp_valid != '0) begin
        if (rq.size() == 0) begin
          check("unexpected_resp", o_resp_valid, 0);
        end else begin
          er = rq.pop_front();
          exp_oh = '0;
          exp_oh[er.m] = 1'b1;
          check("resp_valid", o_resp_valid, exp_oh);
          check("resp_rdata", o_resp_rdata, er.rdata);
          check("resp_err", o_resp_err, er.err);
          check("resp_latency", cyc - gnt_cyc[er.m], er.lat);
          if (er.gw >= 0) check("grant_wait", gwait[er.m], er.gw);
        end
      end
    end
  end

  task automatic req(input int m, input logic [AW-1:0] a, input logic wr, input logic [DW-1:0] wd);
    mreq_t r;
    r.addr = a; r.wr = wr; r.wdata = wd;
    mq[m].push_back(r);
  endtask

  task automatic exp_s(input logic [NSLV-1:0] oh, input logic [AW-1:0] a, input logic wr, input logic [DW-1:0] wd);
    exp_sreq_t e;
    e.oh = oh; e.addr = a; e.wr = wr; e.wdata = wd;
    sq.push_back(e);
  endtask

  task automatic exp_r(input int m, input logic [DW-1:0] rd, input logic [1:0] err, input int lat, input int gw);
    exp_resp_t e;
    e.m = m; e.rdata = rd; e.err = err; e.lat = lat; e.gw = gw;
    rq.push_back(e);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while ((mq[0].size() + mq[1].size() + sq.size() + rq.size()) != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("drain", mq[0].size() + mq[1].size() + sq.size() + rq.size(), 0);
    mq[0].delete(); mq[1].delete(); sq.delete(); rq.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    serr = '0;
    sdata[0] = 64'h0123_4567_89ab_cdef;
    sdata[1] = 64'h1111_2222_3333_4444;
    sdata[2] = 64'h0000_0000_dead_beef;
    sdata[3] = 64'h0000_0000_0000_3c3c;
    sdata[4] = 64'ha5a5_a5a5_0000_0004;
    sdata[5] = 64'h0000_0000_0000_5555;
    for (int s = 0; s < NSLV; s++) dly[s] = 0;

    // Round robin: both masters valid while still in reset (rr = 0), order 0,1,0,1.
    req(0, 64'h0800_0100, 1'b0, '0); req(0, 64'h0800_0200, 1'b0, '0);
    req(1, 64'h0001_0010, 1'b0, '0); req(1, 64'h0001_0020, 1'b0, '0);
    exp_s(6'b000100, 64'h100, 1'b0, '0); exp_r(0, sdata[2], 2'b00, 3, -1);
    exp_s(6'b000001, 64'h10, 1'b0, '0);  exp_r(1, sdata[0], 2'b00, 3, -1);
    exp_s(6'b000100, 64'h200, 1'b0, '0); exp_r(0, sdata[2], 2'b00, 3, 7);
    exp_s(6'b000001, 64'h20, 1'b0, '0);  exp_r(1, sdata[0], 2'b00, 3, 7);
    repeat (3) @(posedge clk);
    #2;
    check("reset_outputs", $countones(outs), 0);
    @(posedge clk);
    #3 rst = 1'b0;
    wait_done(200);

    // Single read to sram.
    req(0, 64'h0801_0000, 1'b0, '0);
    exp_s(6'b000100, 64'h0001_0000, 1'b0, '0); exp_r(0, 64'hdead_beef, 2'b00, 3, 0);
    wait_done(200);

    // Master 1 alone with rr = 1: immediate grant; write with slave error.
    serr[4] = 1'b1;
    req(1, 64'h1000_0040, 1'b1, 64'hcafe);
    exp_s(6'b010000, 64'h0100_0040, 1'b1, 64'hcafe); exp_r(1, sdata[4], 2'b10, 3, 0);
    wait_done(200);
    serr[4] = 1'b0;

    // Overlap: lowest index (plic) wins.
    req(0, 64'h0f00_0010, 1'b0, '0);
    exp_s(6'b001000, 64'h0300_0010, 1'b0, '0); exp_r(0, sdata[3], 2'b00, 3, 0);
    wait_done(200);

    // Window edges and decode misses, back to back on one master.
    req(0, 64'h0800_0000, 1'b0, '0); req(0, 64'h080f_fff8, 1'b0, '0);
    req(0, 64'h0810_0000, 1'b0, '0); req(0, 64'h0000_0000, 1'b0, '0);
    req(0, 64'h4000_0000, 1'b0, '0);
    exp_s(6'b000100, 64'h0, 1'b0, '0);       exp_r(0, sdata[2], 2'b00, 3, 0);
    exp_s(6'b000100, 64'h000f_fff8, 1'b0, '0); exp_r(0, sdata[2], 2'b00, 3, 3);
    exp_r(0, '0, 2'b11, 1, 3);
    exp_r(0, '0, 2'b11, 1, 1);
    exp_r(0, '0, 2'b11, 1, 1);
    wait_done(200);

    // Timeout on ddr, then isolation, then other slaves still work.
    dly[5] = -1;
    req(0, 64'h8000_0100, 1'b0, '0);
    exp_s(6'b100000, 64'h100, 1'b0, '0); exp_r(0, '0, 2'b10, 9, 0);
    wait_done(200);
    req(1, 64'h8000_0000, 1'b0, '0);
    exp_r(1, '0, 2'b10, 1, 0);
    wait_done(200);
    req(0, 64'h0800_0008, 1'b0, '0);
    exp_s(6'b000100, 64'h8, 1'b0, '0); exp_r(0, sdata[2], 2'b00, 3, 0);
    wait_done(200);

    // Response on the exact timeout cycle wins; clint is not marked hung.
    dly[1] = 6;
    req(1, 64'h0200_0008, 1'b0, '0);
    exp_s(6'b000010, 64'h8, 1'b0, '0); exp_r(1, sdata[1], 2'b00, 9, 0);
    wait_done(200);
    dly[1] = 0;
    req(0, 64'h0200_0010, 1'b0, '0);
    exp_s(6'b000010, 64'h10, 1'b0, '0); exp_r(0, sdata[1], 2'b00, 3, 0);
    wait_done(200);

    // Reset while waiting on sram: outputs drop at once, no late response, next request is clean.
    dly[2] = -1;
    req(0, 64'h0800_0040, 1'b0, '0);
    exp_s(6'b000100, 64'h40, 1'b0, '0);
    wait_done(200);
    #2;
    check("in_swait", o_slv_resp_ready, 6'b000100);
    rst = 1'b1;
    #1;
    check("reset_midtxn", $countones(outs), 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    dly[2] = 0;
    repeat (10) @(posedge clk);
    #1;
    req(1, 64'h0800_0048, 1'b0, '0);
    exp_s(6'b000100, 64'h48, 1'b0, '0); exp_r(1, sdata[2], 2'b00, 3, 0);
    wait_done(200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/accel_bus_router.md
# accel_bus_router

Parametrised single-outstanding request router for the accelerator system bus. It generalises the fixed two-master / six-slave bus-0 map to NMST masters and NSLV slaves with a parameter-supplied address map. It adds:
- round-robin master arbitration;
- slave-relative address translation;
- a per-transaction timeout;
- sticky hung-slave isolation.

It sits between the master group (CPU group, PCIe DMA) and the slave decode points (bootrom, clint, sram, plic, APB bridge, DDR).

## Interface
Parameters:
- NMST, 2, number of masters.
- NSLV, 6, number of slaves.
- AW, 64, address width.
- DW, 64, data width.
- MAP_START, NSLV*AW bits, packed start addresses; slave s occupies bits [s*AW +: AW].
- MAP_END, NSLV*AW bits, packed exclusive end addresses, same packing.
- TIMEOUT, 1024, cycles allowed from slave request to slave response; 0 disables the timeout.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous reset, active-high.
- i_req_valid  in  NMST  master request valid.
- i_req_addr  in  NMST*AW  master absolute address.
- i_req_write  in  NMST  1 = write.
- i_req_wdata  in  NMST*DW  write data.
- o_req_ready  out  NMST  request accepted (one-hot, at most one bit).
- o_resp_valid  out  NMST  response valid to master.
- o_resp_rdata  out  DW  response read data (shared).
- o_resp_err  out  2  00 OKAY, 10 SLVERR, 11 DECERR.
- i_resp_ready  in  NMST  master accepts response.
- o_slv_req_valid  out  NSLV  slave request valid (one-hot).
- o_slv_req_addr  out  AW  address relative to MAP_START of the selected slave.
- o_slv_req_write  out  1  write flag.
- o_slv_req_wdata  out  DW  write data.
- i_slv_req_ready  in  NSLV  slave accepts request.
- i_slv_resp_valid  in  NSLV  slave response valid.
- i_slv_resp_rdata  in  NSLV*DW  slave read data.
- i_slv_resp_err  in  NSLV  slave error.
- o_slv_resp_ready  out  NSLV  router accepts the slave response.

## Operation
- FSM states: IDLE, SREQ, SWAIT, RESP.
- **IDLE:**
  - Grant the first valid master scanning from pointer rr upward, modulo NMST.
  - o_req_ready[g] = 1 combinationally in the same cycle.
  - Latch g, the address, the write flag and wdata.
- **Decode (on the latched address):**
  - Hit condition: MAP_START[s] <= addr < MAP_END[s].
  - If several slaves hit, the lowest index wins.
  - Miss → RESP with err 11, rdata 0.
  - Hit on a slave whose hung bit is set → RESP with err 10, rdata 0.
  - Otherwise → SREQ.
- **SREQ:**
  - Drive o_slv_req_valid[s] = 1 and o_slv_req_addr = addr - MAP_START[s].
  - Write flag and wdata are held stable.
  - On i_slv_req_ready[s] → SWAIT.
- **SWAIT:**
  - o_slv_resp_ready[s] = 1.
  - On i_slv_resp_valid[s], latch rdata and err ({1,0} if i_slv_resp_err, else 00) → RESP.
- **Timeout:**
  - A counter of width $clog2(TIMEOUT+1) clears on entry to SREQ and increments each cycle in SREQ/SWAIT.
  - When the counter reaches TIMEOUT (and TIMEOUT != 0):
    - set hung[s];
    - go to RESP with err 10, rdata 0;
    - drop o_slv_req_valid[s] and o_slv_resp_ready[s].
  - If a response and the timeout occur in the same cycle, the response wins.
- **Hung slaves:** hung bits are sticky until reset. Transactions to other slaves proceed normally.
- **RESP:**
  - o_resp_valid[g] = 1; o_resp_rdata and o_resp_err are held stable.
  - On i_resp_ready[g]: rr = (g+1) mod NMST, then → IDLE.
- Requests from ungranted masters wait and are never dropped. Masters must hold their request until o_req_ready.

## Timing
- Reset values:
  - all outputs 0;
  - FSM in IDLE;
  - rr = 0, hung = 0, counter = 0.
- Reset asserted mid-transaction aborts immediately. Outputs are 0 in the same cycle (async), and no response is issued afterwards.
- Latency with a zero-wait slave (ready in cycle 1, response valid in cycle 2):
  - cycle 0: master handshake;
  - cycle 1: o_slv_req_valid;
  - cycle 2: o_slv_resp_ready and response latched;
  - cycle 3: o_resp_valid. Total 3 cycles.
- Decode miss or hung slave: o_resp_valid in cycle 1.
- Exactly one transaction is in flight. IDLE is re-entered on the cycle after the RESP handshake, so back-to-back throughput is 4 cycles per transaction (2 cycles per error).
- Outputs are registered state decodes, except o_req_ready, which is combinational from i_req_valid in IDLE.

## Test plan
- **Single read:** master 0 reads 0x0801_0000 (sram, slave 2), slave returns rdata 0xDEAD_BEEF.
  - o_slv_req_addr = 0x0001_0000 and o_slv_req_valid = 6'b000100.
  - o_resp_valid[0] in cycle 3 with rdata 0xDEAD_BEEF, err 00.
- **Round-robin fairness:** both masters continuously valid from reset.
  - Grant order is 0, 1, 0, 1.
  - Master 1 waiting alone with rr = 1 is granted in the cycle its valid is seen.
- **Decode miss:** address 0x0000_0000.
  - No o_slv_req_valid; o_resp_valid in cycle 1 with err 11, rdata 0.
- **Timeout:** TIMEOUT = 8, slave 5 never asserts resp_valid.
  - err 10 is returned after 8 cycles in SREQ/SWAIT.
  - A second request to slave 5 returns err 10 at cycle 1 with no slave request.
  - A request to slave 2 then completes with OKAY.
- **Simultaneous event and reset:**
  - A slave response in the same cycle as the timeout yields the slave data, with err 00 and hung still 0.
  - i_rst pulsed in SWAIT clears all outputs immediately; a following request completes normally.
